// File: rtl/reg_master_pkg.sv
// reg_master_pkg: state encoding and register-port op codes shared by the burst master.
package reg_master_pkg;
  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_ISSUE, RD_ISSUE, RD_RESP, FIN} state_e;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/reg_burst_addr_gen.sv
// reg_burst_addr_gen: burst address register wrapping at DEPTH plus remaining-word down-counter.
module reg_burst_addr_gen #(
  parameter int REG_ADDR_BITS = 16,
  parameter int DEPTH         = 256,
  parameter int LEN_BITS      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     step_i,
  input  logic [REG_ADDR_BITS-1:0] addr_i,
  input  logic [LEN_BITS-1:0]      len_i,
  output logic [REG_ADDR_BITS-1:0] addr_o,
  output logic [REG_ADDR_BITS-1:0] next_addr_o,
  output logic                     last_o
);
  localparam logic [REG_ADDR_BITS-1:0] LAST_ADDR = REG_ADDR_BITS'(DEPTH - 1);
  logic [REG_ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]      rem_q;
  assign next_addr_o = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
  assign addr_o      = addr_q;
  assign last_o      = rem_q == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (load_i) begin
      addr_q <= addr_i;
      rem_q  <= len_i;
    end else if (step_i) begin
      addr_q <= next_addr_o;
      rem_q  <= rem_q - 1'b1;
    end
  end
endmodule

// File: rtl/reg_burst_master.sv
// reg_burst_master: sequences single/burst register-port accesses from a command channel,
// streaming write data in and read data out over valid/ready.
module reg_burst_master
  import reg_master_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int REG_ADDR_BITS = 16,
  parameter int DEPTH         = 256,
  parameter int LEN_BITS      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [REG_ADDR_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]      cmd_len,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     reg_en,
  output logic                     reg_r_or_w,
  output logic [REG_ADDR_BITS-1:0] reg_addr,
  output logic [WIDTH-1:0]         reg_in,
  input  logic [WIDTH-1:0]         reg_out
);
  localparam logic [REG_ADDR_BITS:0] DEPTH_W = (REG_ADDR_BITS+1)'(DEPTH);
  state_e state_q;
  logic [REG_ADDR_BITS-1:0] addr, next_addr;
  logic last, cmd_fire, bad_addr, load, step;
  assign cmd_fire = state_q == IDLE && cmd_valid && cmd_ready;
  assign bad_addr = {1'b0, cmd_addr} >= DEPTH_W;
  assign load     = cmd_fire && !bad_addr;
  assign step     = !last && ((state_q == WR_ISSUE) || (state_q == RD_RESP && rd_ready));

  reg_burst_addr_gen #(.REG_ADDR_BITS(REG_ADDR_BITS), .DEPTH(DEPTH), .LEN_BITS(LEN_BITS)) u_addr_gen (
    .clk(clk), .rst_n(rst_n), .load_i(load), .step_i(step), .addr_i(cmd_addr), .len_i(cmd_len),
    .addr_o(addr), .next_addr_o(next_addr), .last_o(last)
  );

  // Port strobes default low each cycle so every access lasts exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_ready  <= 1'b0;
      wr_ready   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      reg_en     <= 1'b0;
      reg_r_or_w <= OP_READ;
      reg_addr   <= '0;
      reg_in     <= '0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      reg_en     <= 1'b0;
      reg_r_or_w <= OP_READ;
      reg_addr   <= '0;
      reg_in     <= '0;
      case (state_q)
        IDLE: begin
          cmd_ready <= !load;
          busy      <= load;
          err       <= cmd_fire && bad_addr;
          if (load && cmd_write) begin
            state_q  <= WR_WAIT;
            wr_ready <= 1'b1;
          end else if (load) begin
            state_q  <= RD_ISSUE;
            reg_en   <= 1'b1;
            reg_addr <= cmd_addr;
          end
        end
        WR_WAIT: if (wr_valid) begin
          state_q    <= WR_ISSUE;
          wr_ready   <= 1'b0;
          reg_en     <= 1'b1;
          reg_r_or_w <= OP_WRITE;
          reg_addr   <= addr;
          reg_in     <= wr_data;
        end
        WR_ISSUE: begin
          state_q  <= last ? FIN : WR_WAIT;
          done     <= last;
          wr_ready <= !last;
        end
        RD_ISSUE: begin
          state_q  <= RD_RESP;
          rd_valid <= 1'b1;
          rd_data  <= reg_out;
        end
        RD_RESP: if (rd_ready) begin
          state_q  <= last ? FIN : RD_ISSUE;
          rd_valid <= 1'b0;
          done     <= last;
          reg_en   <= !last;
          reg_addr <= last ? '0 : next_addr;
        end
        FIN: begin
          state_q   <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_burst_master.sv
// tb_reg_burst_master: table-driven bench with an access/read-data scoreboard and a register-file model.
module tb_reg_burst_master;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [15:0] wr_data = '0;
  logic rd_valid, rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic busy, done, err, reg_en, reg_r_or_w;
  logic [15:0] reg_addr, reg_in, reg_out;

  typedef struct packed {logic wr; logic [15:0] addr; logic [15:0] data;} acc_t;
  typedef struct {logic wr; logic [15:0] addr; logic [7:0] len; logic [15:0] seed; int stall_w; int stall_n; logic exp_err;} vec_t;

  acc_t acc_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] mem [0:255];
  logic [15:0] ref_mem [0:255];
  acc_t a_mon;
  logic prev_en = 1'b0;
  int tests = 0, fails = 0, done_cnt = 0, err_cnt = 0;
  vec_t vecs[12];

  always #5 clk = ~clk;

  reg_burst_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .reg_en(reg_en), .reg_r_or_w(reg_r_or_w), .reg_addr(reg_addr), .reg_in(reg_in), .reg_out(reg_out)
  );

  assign reg_out = (reg_en && !reg_r_or_w) ? mem[reg_addr[7:0]] : 16'h0;
  always @(posedge clk) if (reg_en && reg_r_or_w) mem[reg_addr[7:0]] = reg_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every port access must match the next expected access and follow an idle cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (reg_en) begin
      check("en_gap", 64'(prev_en), 64'd0);
      if (acc_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_access: got addr %0h expected none", reg_addr);
      end else begin
        a_mon = acc_q.pop_front();
        check("acc_rw", 64'(reg_r_or_w), 64'(a_mon.wr));
        check("acc_addr", 64'(reg_addr), 64'(a_mon.addr));
        if (a_mon.wr) check("acc_data", 64'(reg_in), 64'(a_mon.data));
      end
    end else check("idle_port_zero", 64'({reg_r_or_w, reg_addr, reg_in}), 64'd0);
    prev_en = reg_en;
  end

  task automatic push_exp(input logic wr, input logic [15:0] addr, input logic [7:0] len, input logic [15:0] seed);
    for (int i = 0; i <= int'(len); i++) begin
      logic [15:0] a;
      a = 16'((32'(addr) + i) % 256);
      if (wr) begin
        ref_mem[a[7:0]] = 16'(seed + 16'(i));
        acc_q.push_back('{1'b1, a, 16'(seed + 16'(i))});
      end else begin
        acc_q.push_back('{1'b0, a, 16'h0});
        rd_q.push_back(ref_mem[a[7:0]]);
      end
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic feed_wr(input logic [15:0] seed, input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) begin
      int n;
      n = 0;
      wr_valid = 1'b1; wr_data = 16'(seed + 16'(i));
      @(negedge clk);
      while (!wr_ready && n < 50) begin @(negedge clk); n++; end
      check("wr_ready_wait", 64'(wr_ready), 64'd1);
      @(posedge clk); #1 wr_valid = 1'b0;
    end
  endtask

  task automatic drain_rd(input int len, input int stall_w, input int stall_n);
    logic [15:0] held, e;
    for (int i = 0; i <= len; i++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (!rd_valid && n < 50) begin @(negedge clk); n++; end
      check("rd_valid_wait", 64'(rd_valid), 64'd1);
      if (i == stall_w) begin
        held = rd_data;
        repeat (stall_n) begin
          @(negedge clk);
          check("stall_valid", 64'(rd_valid), 64'd1);
          check("stall_hold", 64'(rd_data), 64'(held));
          check("stall_no_en", 64'(reg_en), 64'd0);
        end
      end
      e = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hxxxx;
      check("rd_data", 64'(rd_data), 64'(e));
      rd_ready = 1'b1;
      @(posedge clk); #1 rd_ready = 1'b0;
    end
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin @(negedge clk); n++; end
    check("done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check("done_single", 64'(done), 64'd0);
    check("busy_clear", 64'(busy), 64'd0);
    check("cmd_ready_back", 64'(cmd_ready), 64'd1);
    check("acc_q_empty", 64'(acc_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    if (v.exp_err) begin
      send_cmd(v.wr, v.addr, v.len);
      @(negedge clk);
      check("err_pulse", 64'(err), 64'd1);
      check("err_no_busy", 64'(busy), 64'd0);
      check("err_cmd_ready", 64'(cmd_ready), 64'd1);
      @(negedge clk);
      check("err_single", 64'(err), 64'd0);
      check("err_count", 64'(err_cnt - e0), 64'd1);
      check("err_no_done", 64'(done_cnt - d0), 64'd0);
    end else begin
      push_exp(v.wr, v.addr, v.len, v.seed);
      send_cmd(v.wr, v.addr, v.len);
      if (v.wr) feed_wr(v.seed, v.len);
      else drain_rd(int'(v.len), v.stall_w, v.stall_n);
      wait_done();
      repeat (2) @(negedge clk);
      check("done_count", 64'(done_cnt - d0), 64'd1);
      check("err_none", 64'(err_cnt - e0), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'(i * 3 + 1);
      ref_mem[i] = 16'(i * 3 + 1);
    end
    vecs[0]  = '{1'b1, 16'd5,   8'd0,   16'hBEEF, -1, 0, 1'b0};
    vecs[1]  = '{1'b1, 16'd10,  8'd3,   16'h1000, -1, 0, 1'b0};
    vecs[2]  = '{1'b0, 16'd10,  8'd3,   16'h0,    -1, 0, 1'b0};
    vecs[3]  = '{1'b0, 16'd10,  8'd3,   16'h0,     1, 5, 1'b0};
    vecs[4]  = '{1'b1, 16'd254, 8'd3,   16'hA000, -1, 0, 1'b0};
    vecs[5]  = '{1'b0, 16'd254, 8'd3,   16'h0,    -1, 0, 1'b0};
    vecs[6]  = '{1'b1, 16'd300, 8'd0,   16'h0,    -1, 0, 1'b1};
    vecs[7]  = '{1'b0, 16'd256, 8'd2,   16'h0,    -1, 0, 1'b1};
    vecs[8]  = '{1'b0, 16'd255, 8'd0,   16'h0,    -1, 0, 1'b0};
    vecs[9]  = '{1'b1, 16'd0,   8'd255, 16'h2000, -1, 0, 1'b0};
    vecs[10] = '{1'b0, 16'd254, 8'd3,   16'h0,     0, 2, 1'b0};
    vecs[11] = '{1'b0, 16'd0,   8'd255, 16'h0,    -1, 0, 1'b0};
    #3;
    check("reset_outputs", 64'({cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err, reg_en, reg_r_or_w, reg_addr, reg_in}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 12; k++) run_vec(vecs[k]);
    // Read latency: strobe in the cycle after acceptance, data valid one cycle later.
    push_exp(1'b0, 16'd12, 8'd0, 16'h0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'd12; cmd_len = 8'd0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("rd_lat_en", 64'({reg_en, busy, cmd_ready, rd_valid}), 64'b1100);
    @(negedge clk);
    check("rd_lat_valid", 64'({rd_valid, reg_en}), 64'b10);
    drain_rd(0, -1, 0);
    wait_done();
    // Write latency with wr_valid already high (and ignored) while idle.
    push_exp(1'b1, 16'd20, 8'd0, 16'h7777);
    wr_valid = 1'b1; wr_data = 16'h7777;
    send_cmd(1'b1, 16'd20, 8'd0);
    @(negedge clk);
    check("wr_lat_ready", 64'({wr_ready, reg_en}), 64'b10);
    @(negedge clk);
    check("wr_lat_en", 64'({wr_ready, reg_en, reg_r_or_w}), 64'b011);
    wr_valid = 1'b0;
    wait_done();
    check("mem_written", 64'(mem[20]), 64'h7777);
    // Reset while the second word of a four-word read waits for the consumer.
    push_exp(1'b0, 16'd10, 8'd3, 16'h0);
    d0 = done_cnt;
    send_cmd(1'b0, 16'd10, 8'd3);
    drain_rd(0, -1, 0);
    n = 0;
    @(negedge clk);
    while (!rd_valid && n < 50) begin @(negedge clk); n++; end
    check("rst_pre_valid", 64'(rd_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", 64'({cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err, reg_en, reg_r_or_w, reg_addr, reg_in}), 64'd0);
    acc_q.delete();
    rd_q.delete();
    repeat (3) @(negedge clk);
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    rst_n = 1'b1;
    run_vec('{1'b0, 16'd11, 8'd0, 16'h0, -1, 0, 1'b0});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_burst_master.md
Name: reg_burst_master

Overview:
- Initiator for the register-file access port (en, r_or_w, reg_addr, in, out).
- Accepts single or burst read/write commands on a valid/ready command channel.
- Streams write data in and read data out over valid/ready channels.
- Sequences one-cycle register-port strobes with incrementing, wrapping addresses; sits between the control FSM/host and the register file.

Parameters:
- WIDTH, 16, data word width (matches register file).
- REG_ADDR_BITS, 16, register address width.
- DEPTH, 256, number of implemented registers; legal addresses 0..DEPTH-1.
- LEN_BITS, 8, burst length field width (words = cmd_len+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  REG_ADDR_BITS  start address.
- cmd_len  in  LEN_BITS  word count minus one.
- wr_valid  in  1  write data present.
- wr_ready  out  1  write data accepted.
- wr_data  in  WIDTH  write word.
- rd_valid  out  1  read word present.
- rd_ready  in  1  consumer accepts read word.
- rd_data  out  WIDTH  read word.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, burst complete.
- err  out  1  one-cycle pulse, illegal start address.
- reg_en  out  1  register port enable.
- reg_r_or_w  out  1  1 = write, 0 = read.
- reg_addr  out  REG_ADDR_BITS  register address.
- reg_in  out  WIDTH  register write data.
- reg_out  in  WIDTH  register read data (valid same cycle as reg_en&!reg_r_or_w).

Behaviour:
- Reset: clk is the only clock; rst_n asynchronous, active-low. Every output is registered and resets to 0; state resets to IDLE. Reset mid-burst abandons the burst with no done/err and drops reg_en immediately.
- States: IDLE, WR_WAIT, WR_ISSUE, RD_ISSUE, RD_RESP, FIN.
- IDLE: cmd_ready=1.
  - On cmd_valid with cmd_addr >= DEPTH: err=1 next cycle, stay IDLE, no port access.
  - Otherwise latch addr and remaining=cmd_len, then go to WR_WAIT (write) or RD_ISSUE (read).
- WR_WAIT: wr_ready=1. On wr_valid, load reg_in=wr_data, reg_addr=addr, reg_r_or_w=1, reg_en=1, and enter WR_ISSUE.
- WR_ISSUE: reg_en high for exactly this one cycle. Next cycle reg_en=0.
  - remaining==0: go to FIN.
  - Otherwise: addr++, remaining--, go to WR_WAIT.
- RD_ISSUE: reg_en=1, reg_r_or_w=0, reg_addr=addr for one cycle. reg_out is captured into rd_data at the closing edge; then rd_valid=1 and go to RD_RESP.
- RD_RESP: rd_valid and rd_data are held stable until rd_ready.
  - On handshake with remaining==0: go to FIN.
  - Otherwise: addr++, remaining--, go to RD_ISSUE.
- FIN: done=1 for one cycle, then IDLE. cmd_ready stays 0 in FIN.
- Latency: command accepted at edge T. A read has reg_en high in cycle T+1 and rd_valid from T+2. A write with wr_valid already high at T+1 has reg_en high in T+2.
- Throughput: at most one access per 2 cycles. reg_en is always low for at least 1 cycle between accesses. reg_addr, reg_in and reg_r_or_w are stable for the whole reg_en cycle.
- Address wrap: DEPTH-1 increments to 0, not DEPTH. Burst length up to 2^LEN_BITS words, counted exactly.
- Handshake rules:
  - wr_ready=0 and rd_valid=0 outside their states.
  - A wr_valid arriving in IDLE is ignored until WR_WAIT.
  - cmd_valid is ignored while busy.
- When reg_en=0, reg_r_or_w, reg_addr and reg_in are driven to 0.

Decomposition:
- Package reg_master_pkg: state enum (IDLE..FIN), OP_READ=0/OP_WRITE=1 constants.
- One sub-module, reg_burst_addr_gen: address register with DEPTH wrap plus remaining-word down-counter, with load/step inputs and a last flag.

Test Plan:
- Single write: cmd_write=1, addr=0x0005, len=0, wr_data=0xBEEF -> exactly one reg_en cycle with r_or_w=1, addr=5, in=0xBEEF; done pulses once; busy returns 0.
- Read burst: register file preloaded 10..13 with 0x1000..0x1003, read addr=10, len=3, rd_ready=1 -> four reg_en read cycles at addr 10..13; rd_data 0x1000..0x1003 in order; reg_en gap of at least 1 cycle between accesses.
- Backpressure: same read with rd_ready low for 5 cycles on the 2nd word -> rd_data=0x1001 held stable, no reg_en during the stall, no word lost or duplicated.
- Wrap: write burst addr=254, len=3, DEPTH=256 -> accesses at 254, 255, 0, 1; done after the 4th.
- Illegal address: cmd_addr=300 -> err single pulse, no reg_en, done stays 0, cmd_ready high the next cycle.
- Reset mid-burst: rst_n low during RD_RESP of word 2 of 4 -> all outputs 0 immediately, no done; a new single read after release completes normally.
